fifo: RTL and testbench
=======================

Name: fifo

Overview:
- Synchronous single-clock first-in-first-out queue with a parameterised element type and depth.
- Used as a generic buffering primitive between pipeline stages of the out-of-order core (e.g. fetch/decode queues, dispatch buffers).
- Provides full/empty status and a registered read port with one-cycle latency.

Parameters:
- T, logic [31:0], element data type (any packed type); the storage width is $bits(T).
- DEPTH, 8, number of entries; must be at least 2 and a power of two.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- write_en  in  1  push request; accepted only when not full.
- write_data  in  T  data to push; sampled on the accepting edge.
- read_en  in  1  pop request; accepted only when not empty.
- read_data  out  T  registered head element; updated on the edge that accepts a pop.
- full  out  1  high when occupancy == DEPTH.
- empty  out  1  high when occupancy == 0.

Interface:
- One clock (clk). Reset (reset) is synchronous and active-high. Polarity and synchronicity are fixed.

Behaviour:
- State: storage array mem[DEPTH], wr_ptr and rd_ptr of width $clog2(DEPTH), and occupancy count of width $clog2(DEPTH)+1.
- Reset, sampled at posedge with reset=1:
  - wr_ptr=0, rd_ptr=0, count=0.
  - read_data='0.
  - empty=1, full=0.
  - Storage contents are don't-care. Reset mid-operation discards all entries immediately.
- Accepted operations:
  - push_ok = write_en && !full.
  - pop_ok = read_en && !empty.
  - Both are evaluated on the flags as they stand before the edge, i.e. the occupancy left by the previous cycle.
- Push: mem[wr_ptr] <= write_data; wr_ptr increments and wraps DEPTH-1 -> 0.
- Pop: read_data <= mem[rd_ptr]; rd_ptr increments and wraps. The popped value is visible on read_data from just after the accepting edge until the next pop.
- No pop: read_data holds its previous value.
- Count:
  - +1 on push only, -1 on pop only.
  - Unchanged when both are accepted, or when neither is.
- Flags are combinational from count (or registered equivalents); either way they must reflect the current count:
  - full = (count == DEPTH).
  - empty = (count == 0).
- Write when full: ignored. No state change, no overwrite. A simultaneous pop is still accepted, and count becomes DEPTH-1.
- Read when empty: ignored. read_data holds. A simultaneous push is accepted, and count becomes 1. There is no write-to-read bypass: the pushed data appears on read_data only after a later pop.
- Simultaneous push and pop with 0 < count < DEPTH:
  - Both execute and count is unchanged.
  - When rd_ptr == wr_ptr cannot occur in this case, the pop returns the older entry.
- Ordering: strict FIFO. Data survives any number of pointer wrap-arounds.
- No assertions or X-propagation on illegal requests. They are silently dropped.

Decomposition:
- Shared package fifo_pkg:
  - default DATA_W = 32.
  - typedef logic [DATA_W-1:0] word_t.
  - helper function for the pointer width via $clog2.
- One natural sub-module, fifo_storage: a DEPTH x T register array with one write port and one registered read port (wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_data).
- The top level holds the pointers, count and flags.

Test Plan:
- Reset: hold reset 3 cycles -> empty=1, full=0, read_data=0. A read_en pulse afterwards leaves read_data=0 and empty=1.
- Fill and drain: push 0x11..0x18 (8 writes) -> full=1 after the 8th edge. A 9th push of 0xFF is dropped. Then 8 pops return 0x11..0x18 in order, each valid one cycle after read_en. empty=1 after the last pop.
- Wrap-around: push 5, pop 5, then push 0xA0..0xA7 -> full=1. The pops return 0xA0..0xA7, exercising pointer wrap.
- Simultaneous operations:
  - At count=3, push 0xBEEF and pop together -> count stays 3, the pop returns the oldest entry.
  - At full, write+read together -> pop accepted, write dropped, full=0.
  - At empty, write 0x42 + read together -> read ignored, empty=0. The next pop returns 0x42.
- Reset mid-operation: with 4 entries, assert reset one cycle -> empty=1, read_data=0. A subsequent push 0x7 and pop returns 0x7.
- Random soak: 500 cycles of random push/pop gated by a model queue -> flags match the model occupancy every cycle and all popped data matches.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types and helpers for the synchronous FIFO block.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Default element width when the FIFO is used with its default type.
  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;

  // Pointer width for a given depth; clamped so a degenerate depth still
  // yields a legal one-bit vector.
  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_storage.sv
`default_nettype none
// ============================================================================
// Module      : fifo_storage
// Description : DEPTH x T register array, one write port and one registered
//               read port. The read register clears on reset; the array
//               itself is not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_storage
  import fifo_pkg::*;
#(
  parameter type T      = word_t,
  parameter int  DEPTH  = 8,
  parameter int  ADDR_W = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  T                  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output T                  rd_data
);

  T mem_q [DEPTH];
  T rd_data_q;

  // Write port: store the incoming element at the write address.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read port: capture the addressed element on an accepted pop, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule : fifo_storage
`default_nettype wire

// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
// Module      : fifo
// Description : Synchronous single-clock FIFO with parameterised element type
//               and power-of-two depth. Holds the pointers, occupancy count
//               and status flags; data lives in fifo_storage.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo
  import fifo_pkg::*;
#(
  parameter type T     = word_t,
  parameter int  DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic write_en,
  input  T     write_data,
  input  logic read_en,
  output T     read_data,
  output logic full,
  output logic empty
);

  localparam int                 c_PTR_W    = ptr_width(DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [c_PTR_W:0]   c_CNT_ONE  = (c_PTR_W + 1)'(1);
  localparam logic [c_PTR_W:0]   c_CNT_FULL = (c_PTR_W + 1)'(DEPTH);

  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_PTR_W:0]   count_q,  count_d;
  logic               push_ok;
  logic               pop_ok;

  // Flags follow the registered count, so requests are judged against the
  // occupancy left by the previous cycle.
  assign full    = (count_q == c_CNT_FULL);
  assign empty   = (count_q == '0);
  assign push_ok = write_en && !full;
  assign pop_ok  = read_en && !empty;

  // Next-state for pointers and occupancy; pointers wrap naturally since
  // DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + c_PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + c_PTR_ONE;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + c_CNT_ONE;
      2'b01:   count_d = count_q - c_CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards all entries at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Read and write addresses never collide on an accepted pair: a
  // simultaneous push/pop only happens with 0 < count < DEPTH.
  fifo_storage #(
    .T      (T),
    .DEPTH  (DEPTH),
    .ADDR_W (c_PTR_W)
  ) u_storage (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (write_data),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr_q),
    .rd_data (read_data)
  );

endmodule : fifo
`default_nettype wire

// File: tb/tb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo
// Description : Self-checking bench for fifo with a queue-based scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        write_en = 1'b0;
  logic [31:0] write_data = '0;
  logic        read_en = 1'b0;
  logic [31:0] read_data;
  logic        full;
  logic        empty;

  logic [31:0] exp_q[$];
  logic [31:0] exp_rd = '0;
  int          n_tests = 0;
  int          n_fail  = 0;

  fifo #(
    .T     (logic [31:0]),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .write_en   (write_en),
    .write_data (write_data),
    .read_en    (read_en),
    .read_data  (read_data),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; the model is advanced with the acceptance
  // decision taken from its own pre-edge occupancy.
  task automatic step(input logic we, input logic [31:0] wd, input logic re);
    logic push_ok;
    logic pop_ok;
    write_en   = we;
    write_data = wd;
    read_en    = re;
    push_ok    = we && (exp_q.size() < DEPTH);
    pop_ok     = re && (exp_q.size() != 0);
    @(posedge clk);
    #1;
    if (pop_ok) exp_rd = exp_q.pop_front();
    if (push_ok) exp_q.push_back(wd);
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset    = 1'b1;
    write_en = 1'b0;
    read_en  = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_rd = '0;
  endtask

  task automatic test_reset();
    do_reset(3);
    if (empty !== 1'b1 || full !== 1'b0 || read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: empty=%b full=%b rd=%h, want empty=1 full=0 rd=0",
               empty, full, read_data);
    end
    n_tests++;
    step(1'b0, 32'h0, 1'b1);
    if (empty !== 1'b1 || read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_read_empty: empty=%b rd=%h, want empty=1 rd=0", empty, read_data);
    end
    n_tests++;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 32'h11 + i, 1'b0);
      if (full !== (i == DEPTH - 1) || empty !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_flags[%0d]: full=%b empty=%b, want full=%b empty=0",
                 i, full, empty, (i == DEPTH - 1));
      end
      n_tests++;
    end
    step(1'b1, 32'hFF, 1'b0);
    if (full !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_full: full=%b, want 1", full);
    end
    n_tests++;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (read_data !== exp_rd || read_data !== 32'h11 + i) begin
        n_fail++;
        $display("FAIL drain_data[%0d]: got %h, want %h", i, read_data, 32'h11 + i);
      end
      n_tests++;
    end
    if (empty !== 1'b1 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: empty=%b full=%b, want empty=1 full=0", empty, full);
    end
    n_tests++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) step(1'b1, 32'h1 + i, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (read_data !== exp_rd) begin
        n_fail++;
        $display("FAIL wrap_pre[%0d]: got %h, want %h", i, read_data, exp_rd);
      end
      n_tests++;
    end
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'hA0 + i, 1'b0);
    if (full !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_full: full=%b, want 1", full);
    end
    n_tests++;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (read_data !== exp_rd || read_data !== 32'hA0 + i) begin
        n_fail++;
        $display("FAIL wrap_data[%0d]: got %h, want %h", i, read_data, 32'hA0 + i);
      end
      n_tests++;
    end
  endtask

  task automatic test_simultaneous();
    // Mid occupancy: both accepted, oldest returned.
    for (int i = 0; i < 3; i++) step(1'b1, 32'hC1 + i, 1'b0);
    step(1'b1, 32'hBEEF, 1'b1);
    if (read_data !== 32'hC1 || exp_q.size() != 3 || full !== 1'b0 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_mid: rd=%h full=%b empty=%b, want rd=c1 full=0 empty=0",
               read_data, full, empty);
    end
    n_tests++;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (read_data !== exp_rd) begin
        n_fail++;
        $display("FAIL simul_mid_drain[%0d]: got %h, want %h", i, read_data, exp_rd);
      end
      n_tests++;
    end
    // Full: pop accepted, push dropped.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'hD0 + i, 1'b0);
    step(1'b1, 32'hEE, 1'b1);
    if (read_data !== 32'hD0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_full: rd=%h full=%b, want rd=d0 full=0", read_data, full);
    end
    n_tests++;
    for (int i = 1; i < DEPTH; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (read_data !== exp_rd || read_data !== 32'hD0 + i) begin
        n_fail++;
        $display("FAIL simul_full_drain[%0d]: got %h, want %h", i, read_data, 32'hD0 + i);
      end
      n_tests++;
    end
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_full_empty: empty=%b, want 1", empty);
    end
    n_tests++;
    // Empty: pop ignored, push accepted, no bypass.
    step(1'b1, 32'h42, 1'b1);
    if (empty !== 1'b0 || read_data !== 32'hD7) begin
      n_fail++;
      $display("FAIL simul_empty: empty=%b rd=%h, want empty=0 rd=d7", empty, read_data);
    end
    n_tests++;
    step(1'b0, 32'h0, 1'b1);
    if (read_data !== 32'h42 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_empty_pop: rd=%h empty=%b, want rd=42 empty=1", read_data, empty);
    end
    n_tests++;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h50 + i, 1'b0);
    do_reset(1);
    if (empty !== 1'b1 || full !== 1'b0 || read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_state: empty=%b full=%b rd=%h, want empty=1 full=0 rd=0",
               empty, full, read_data);
    end
    n_tests++;
    step(1'b1, 32'h7, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    if (read_data !== 32'h7 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pop: rd=%h empty=%b, want rd=7 empty=1", read_data, empty);
    end
    n_tests++;
  endtask

  task automatic test_random_soak();
    for (int c = 0; c < 500; c++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      if (full !== (exp_q.size() == DEPTH) || empty !== (exp_q.size() == 0)) begin
        n_fail++;
        $display("FAIL soak_flags[%0d]: full=%b empty=%b, want occupancy %0d",
                 c, full, empty, exp_q.size());
      end
      n_tests++;
      if (read_data !== exp_rd) begin
        n_fail++;
        $display("FAIL soak_data[%0d]: got %h, want %h", c, read_data, exp_rd);
      end
      n_tests++;
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_mid_reset();
    test_random_soak();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fifo
`default_nettype wire
